// File: rtl/nn_pkg.sv
// Shared fixed-point constants, FSM states and the shift-and-clamp helper
// used by the neuron MAC and the downstream activation stages.
package nn_pkg;

    localparam int BITS_DEF = 16;
    localparam int FRAC     = BITS_DEF / 2;
    localparam int ONE_Q    = 1 << FRAC;

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } sat_t;

    // Floor shift by bits/2, then clamp into a signed bits-wide range.
    function automatic sat_t sat_shift(
        input logic signed [63:0] v,
        input int                 bits
    );
        sat_t               r;
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = v >>> (bits / 2);
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        r.val = s;
        r.sat = 1'b0;
        if (s > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (s < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac_fx_sat_shift.sv
// Combinational floor shift by BITS/2 and signed clamp to BITS,
// reporting whether the value had to be clipped.
import nn_pkg::*;

module fx_sat_shift #(
    parameter int IN_W = 40,
    parameter int BITS = 16
) (
    input  logic signed [IN_W-1:0] din,
    output logic signed [BITS-1:0] dout,
    output logic                   sat
);

    sat_t               r;
    logic signed [63:0] wide;
    logic               unused_hi;

    always_comb begin
        wide = {{(64-IN_W){din[IN_W-1]}}, din};
        r    = sat_shift(wide, BITS);
    end

    assign dout      = r.val[BITS-1:0];
    assign sat       = r.sat;
    assign unused_hi = ^r.val[63:BITS];

endmodule

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate neuron: z = sum(x*w) + b in signed
// Q(BITS/2).(BITS/2), saturated, one result per neuron.
import nn_pkg::*;

module neuron_mac #(
    parameter int BITS  = 16,
    parameter int GUARD = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BITS-1:0] in_x,
    input  logic signed [BITS-1:0] in_w,
    input  logic                   in_last,
    input  logic signed [BITS-1:0] in_bias,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BITS-1:0] out_z,
    output logic                   out_sat
);

    localparam int F  = BITS / 2;
    localparam int PW = 2 * BITS;
    localparam int AW = 2 * BITS + GUARD;

    state_t state;
    state_t state_nxt;

    logic signed [AW-1:0]     acc;
    logic signed [AW-1:0]     sum_beat;
    logic signed [AW-1:0]     sum_last;
    logic signed [PW-1:0]     prod;
    logic signed [BITS+F-1:0] bias_sh;
    logic [GUARD-1:0]         cnt;

    logic                   fire;
    logic                   cnt_full;
    logic                   term;
    logic                   forced;
    logic signed [BITS-1:0] z_sat;
    logic                   clip;

    // Gating with rst_n keeps the stream closed while reset is held.
    assign in_ready = rst_n & (state == ACC);
    assign fire     = in_valid & in_ready;
    assign cnt_full = &cnt;
    assign term     = fire & (in_last | cnt_full);
    assign forced   = cnt_full & ~in_last;

    assign prod     = PW'(in_x) * PW'(in_w);
    assign bias_sh  = {in_bias, {F{1'b0}}};
    assign sum_beat = acc + AW'(prod);
    assign sum_last = sum_beat + AW'(bias_sh);

    fx_sat_shift #(
        .IN_W (AW),
        .BITS (BITS)
    ) u_sat (
        .din  (sum_last),
        .dout (z_sat),
        .sat  (clip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        unique case (state)
            ACC: begin
                if (term) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            out_z   <= '0;
            out_sat <= 1'b0;
        end else if (term) begin
            acc     <= '0;
            cnt     <= '0;
            out_z   <= z_sat;
            out_sat <= clip | forced;
        end else if (fire) begin
            acc <= sum_beat;
            cnt <= cnt + GUARD'(1);
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized and directed scoreboard bench for neuron_mac.
// Expected sums come from plain integer arithmetic on each neuron's beats.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_w = '0;
    logic        in_last = 1'b0;
    logic [15:0] in_bias = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_z;
    logic        out_sat;

    typedef struct {
        logic [15:0] z;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   or_mode = 0;

    neuron_mac #(
        .BITS  (16),
        .GUARD (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Real-valued meaning: floor((dot + bias*2^8) / 2^8), clamped to int16.
    function automatic exp_t model(input longint dot, input logic [15:0] bias, input bit forced);
        exp_t   e;
        longint t;
        longint q;
        t = dot + longint'($signed(bias)) * 256;
        q = t / 256;
        if (t < 0 && (t % 256) != 0) q = q - 1;
        e.sat = forced;
        if (q > 32767) begin
            q = 32767;
            e.sat = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            e.sat = 1'b1;
        end
        e.z = q[15:0];
        return e;
    endfunction

    task automatic push(input logic [15:0] z, input logic sat);
        exp_t e;
        e.z = z;
        e.sat = sat;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic beat(input logic [15:0] x, input logic [15:0] w, input logic last,
                        input logic [15:0] b, output int waits);
        logic rdy;
        in_x = x;
        in_w = w;
        in_last = last;
        in_bias = b;
        in_valid = 1'b1;
        waits = 0;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            waits++;
            if (waits > 2000) begin
                $display("FAIL beat_timeout: got no in_ready expected accept");
                $fatal(1, "timeout");
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) check("drain_timeout", k, 0);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 2) != 0) v = {{6{v[9]}}, v[9:0]};
        return v;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_z", out_z, e.z);
                    check("out_sat", out_sat, e.sat);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (or_mode)
                0: out_ready = ($urandom_range(0, 2) != 0);
                1: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        int          w8;
        int          n;
        longint      dot;
        logic [15:0] x;
        logic [15:0] w;
        logic [15:0] b;
        exp_t        e;

        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 0);
        check("rst_out_sat", out_sat, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum; bias on the non-last beat must be ignored.
        push(16'h02C0, 1'b0);
        beat(16'h0100, 16'h0200, 1'b0, 16'h7777, w8);
        beat(16'h0080, 16'h0100, 1'b1, 16'h0040, w8);
        check("latency_valid", out_valid, 1);

        push(16'hFE80, 1'b0);
        beat(16'hFF00, 16'h0180, 1'b1, 16'h0000, w8);
        push(16'h0000, 1'b0);
        beat(16'h0001, 16'h0001, 1'b1, 16'h0000, w8);
        push(16'hFFFF, 1'b0);
        beat(16'hFFFF, 16'h0001, 1'b1, 16'h0000, w8);
        push(16'h7FFF, 1'b1);
        beat(16'h7F00, 16'h7F00, 1'b1, 16'h0000, w8);
        push(16'h8000, 1'b1);
        beat(16'h8000, 16'h7F00, 1'b1, 16'h0000, w8);
        idle(1);

        // Backpressure with the next beat already offered.
        wait_drain();
        or_mode = 1;
        idle(2);
        push(16'h0300, 1'b0);
        beat(16'h0200, 16'h0180, 1'b1, 16'h0000, w8);
        in_x = 16'h0100;
        in_w = 16'h0100;
        in_last = 1'b1;
        in_bias = 16'h0000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_z", out_z, 16'h0300);
            if (i == 2) or_mode = 2;
            @(negedge clk);
        end
        push(16'h0100, 1'b0);
        beat(16'h0100, 16'h0100, 1'b1, 16'h0000, w8);
        check("bp_restart_wait", w8, 1);
        or_mode = 0;
        idle(1);

        // Forced termination after 2^GUARD beats with no in_last.
        wait_drain();
        push(16'h0100, 1'b1);
        for (int i = 0; i < 256; i++) begin
            beat(16'h0100, 16'h0001, 1'b0, 16'h0000, w8);
            if (i == 254) check("forced_not_early", out_valid, 0);
        end
        check("forced_valid", out_valid, 1);
        idle(1);

        // Reset mid-neuron discards the partial sum.
        wait_drain();
        beat(16'h0100, 16'h0200, 1'b0, 16'h0000, w8);
        beat(16'h0300, 16'h0100, 1'b0, 16'h0000, w8);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(16'h0100, 1'b0);
        beat(16'h0100, 16'h0100, 1'b1, 16'h0000, w8);
        idle(1);

        // Random neurons with bubbles and random backpressure.
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(1, 6);
            dot = 0;
            for (int i = 0; i < n; i++) begin
                x = rand_val();
                w = rand_val();
                b = rand_val();
                dot += longint'($signed(x)) * longint'($signed(w));
                if (i == n - 1) begin
                    e = model(dot, b, 1'b0);
                    sb.push_back(e);
                end
                beat(x, w, (i == n - 1), b, w8);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(1);
        wait_drain();
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
